// File: rtl/adc_capture_ctrl.sv
// Triggered one-shot capture sequencer: settle, level-crossing trigger, then a gap-free 2^ADDR_W sample burst.
// Optional macro ADC_CAPTURE_TRIG_EN compiles in the trigger comparator and timeout; otherwise WAIT_TRIG lasts one cycle.
module adc_capture_ctrl #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 12,
    parameter int SETTLE_CYCLES = 256,
    parameter int TRIG_TIMEOUT  = 65535
) (
    input  logic              adc_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_buf_wr,
    output logic [ADDR_W-1:0] adc_buf_addr,
    output logic [DATA_W-1:0] adc_buf_data,
    output logic              busy,
    output logic              done,
    output logic              trig_forced,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > TRIG_TIMEOUT) ? SETTLE_CYCLES : TRIG_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              r_forced;
    logic              w_start_ok;
    logic              w_forced_set;
    logic              w_last;

    assign w_last = (r_addr == {ADDR_W{1'b1}});

`ifdef ADC_CAPTURE_TRIG_EN
    logic r_rising;
    logic w_cross;
    logic w_timeout;

    // Crossing is judged on the two most recent pipelined samples, d2 older than d1.
    assign w_cross   = r_rising ? ((r_d2 < trig_level) && (r_d1 >= trig_level))
                                : ((r_d2 >= trig_level) && (r_d1 < trig_level));
    assign w_timeout = (TRIG_TIMEOUT != 0) && (r_cnt == CNT_W'(TRIG_TIMEOUT - 1));
`else
    logic w_unused_trig;
    assign w_unused_trig = ^{trig_level, trig_rising};
`endif

    always_comb begin
        w_next       = r_state;
        w_start_ok   = 1'b0;
        w_forced_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    w_next     = (SETTLE_CYCLES == 0) ? S_WAIT : S_ARM;
                end
            end
            S_ARM: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES)) w_next = S_WAIT;
            end
            S_WAIT: begin
`ifdef ADC_CAPTURE_TRIG_EN
                if (w_cross) begin
                    w_next = S_CAP;
                end else if (w_timeout) begin
                    w_next       = S_CAP;
                    w_forced_set = 1'b1;
                end
`else
                w_next = S_CAP;
`endif
            end
            S_CAP: begin
                if (w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next       = S_IDLE;
            w_start_ok   = 1'b0;
            w_forced_set = 1'b0;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_forced <= 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
            r_rising <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_d1    <= adc_data;
            r_d2    <= r_d1;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_done  <= (r_state == S_CAP) && w_last && !abort;
            // Each write carries the sample that sat in d1 during the preceding cycle.
            if (w_next == S_CAP) begin
                r_data <= r_d1;
                r_addr <= (r_state == S_CAP) ? r_addr + ADDR_W'(1) : '0;
            end
            if (w_start_ok) begin
                r_forced <= 1'b0;
            end else if (w_forced_set) begin
                r_forced <= 1'b1;
            end
`ifdef ADC_CAPTURE_TRIG_EN
            if (w_start_ok) r_rising <= trig_rising;
`endif
        end
    end

    assign adc_buf_wr   = (r_state == S_CAP);
    assign adc_buf_addr = r_addr;
    assign adc_buf_data = r_data;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign trig_forced  = r_forced;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed and random stimulus against a sample-history reference model.
// Two instances share all inputs: one with a settle interval of 3, one with no settle interval.
module tb_adc_capture_ctrl;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 10;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int SETTLE0 = 3;
    localparam int SETTLE1 = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              trig_rising;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] adc_data;

    logic              o_wr     [2];
    logic [ADDR_W-1:0] o_addr   [2];
    logic [DATA_W-1:0] o_data   [2];
    logic              o_busy   [2];
    logic              o_done   [2];
    logic              o_forced [2];
    logic [1:0]        o_state  [2];

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE0), .TRIG_TIMEOUT(TIMEOUT)
    ) dut0 (
        .adc_clk(clk), .rst(rst), .start(start), .abort(abort),
        .trig_level(trig_level), .trig_rising(trig_rising), .adc_data(adc_data),
        .adc_buf_wr(o_wr[0]), .adc_buf_addr(o_addr[0]), .adc_buf_data(o_data[0]),
        .busy(o_busy[0]), .done(o_done[0]), .trig_forced(o_forced[0]), .dbg_state(o_state[0])
    );

    adc_capture_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE1), .TRIG_TIMEOUT(TIMEOUT)
    ) dut1 (
        .adc_clk(clk), .rst(rst), .start(start), .abort(abort),
        .trig_level(trig_level), .trig_rising(trig_rising), .adc_data(adc_data),
        .adc_buf_wr(o_wr[1]), .adc_buf_addr(o_addr[1]), .adc_buf_data(o_data[1]),
        .busy(o_busy[1]), .done(o_done[1]), .trig_forced(o_forced[1]), .dbg_state(o_state[1])
    );

    // Reference model: hist[e] is the sample captured into d1 at edge e.
    logic [DATA_W-1:0] hist[$];
    int                settle_p [2] = '{SETTLE0, SETTLE1};
    bit                m_act    [2];
    bit                m_rise   [2];
    int                m_w0     [2];
    int                m_c0     [2];
    bit                e_wr     [2];
    bit                e_busy   [2];
    bit                e_done   [2];
    bit                e_forced [2];
    int                e_addr   [2];
    logic [DATA_W-1:0] e_data   [2];

    int n_vec = 0;
    int n_err = 0;
    bit found;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

`ifdef ADC_CAPTURE_TRIG_EN
    function automatic bit crossed(input bit rising, input logic [DATA_W-1:0] prev,
                                   input logic [DATA_W-1:0] cur, input logic [DATA_W-1:0] level);
        if (rising) return (prev < level) && (cur >= level);
        return (prev >= level) && (cur < level);
    endfunction
`endif

    // One edge of instance m. w0 is the edge that enters WAIT_TRIG, c0 the edge of the first write.
    task automatic model_step(input int m, input int e);
        int k;
        int i;
        bit hit;
        e_done[m] = 1'b0;
        if (rst) begin
            m_act[m]    = 1'b0;
            e_wr[m]     = 1'b0;
            e_busy[m]   = 1'b0;
            e_forced[m] = 1'b0;
            e_addr[m]   = 0;
            e_data[m]   = '0;
        end else if (abort) begin
            m_act[m]  = 1'b0;
            e_wr[m]   = 1'b0;
            e_busy[m] = 1'b0;
        end else if (!m_act[m]) begin
            e_wr[m] = 1'b0;
            if (start) begin
                m_act[m]    = 1'b1;
                m_rise[m]   = trig_rising;
                e_forced[m] = 1'b0;
                e_busy[m]   = 1'b1;
                m_w0[m]     = (settle_p[m] == 0) ? e : e + settle_p[m] + 1;
                m_c0[m]     = -1;
            end
        end else begin
            if (m_c0[m] < 0 && e - 1 >= m_w0[m]) begin
                k   = e - 1;
                hit = 1'b1;
`ifdef ADC_CAPTURE_TRIG_EN
                hit = crossed(m_rise[m], hist[k-1], hist[k], trig_level);
                if (hit) begin
                    m_c0[m] = e;
                end else if (TIMEOUT != 0 && k - m_w0[m] + 1 == TIMEOUT) begin
                    m_c0[m]     = e;
                    e_forced[m] = 1'b1;
                end
`else
                if (hit) m_c0[m] = e;
`endif
            end
            if (m_c0[m] >= 0) begin
                i = e - m_c0[m];
                if (i < DEPTH) begin
                    e_wr[m]   = 1'b1;
                    e_addr[m] = i;
                    e_data[m] = hist[e-1];
                end else begin
                    e_wr[m]   = 1'b0;
                    e_busy[m] = 1'b0;
                    e_done[m] = 1'b1;
                    m_act[m]  = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        int e;
        e = hist.size();
        hist.push_back(rst ? '0 : adc_data);
        model_step(0, e);
        model_step(1, e);
    end

    always @(negedge clk) begin
        if (hist.size() > 0) begin
            for (int m = 0; m < 2; m++) begin
                chk_eq($sformatf("wr%0d", m), 32'(o_wr[m]), 32'(e_wr[m]));
                chk_eq($sformatf("busy%0d", m), 32'(o_busy[m]), 32'(e_busy[m]));
                chk_eq($sformatf("done%0d", m), 32'(o_done[m]), 32'(e_done[m]));
                chk_eq($sformatf("forced%0d", m), 32'(o_forced[m]), 32'(e_forced[m]));
                chk_eq($sformatf("addr%0d", m), 32'(o_addr[m]), 32'(e_addr[m]));
                if (e_wr[m]) chk_eq($sformatf("data%0d", m), 32'(o_data[m]), 32'(e_data[m]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        trig_rising = 1'b1;
        trig_level  = 12'h800;
        adc_data    = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Rising ramp through 0x800
        adc_data = 12'h700;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        for (int i = 0; i < 40; i++) begin
            adc_data = 12'h7F0 + 12'(4 * i);
            step();
        end

        // Falling trigger at 0x400; the rising pass through 0x400 must not fire
        trig_level  = 12'h400;
        trig_rising = 1'b0;
        adc_data    = 12'h3F8;
        start       = 1'b1;
        step();
        start       = 1'b0;
        trig_rising = 1'b1;
        adc_data = 12'h3FC; step();
        adc_data = 12'h400; step();
        adc_data = 12'h404; step();
        adc_data = 12'h500; step();
        adc_data = 12'h450; step();
        adc_data = 12'h3F0;
        repeat (40) step();

        // Timeout on a flat input, then a fresh start clears trig_forced
        trig_level = 12'h800;
        adc_data   = 12'h100;
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (40) step();
        end

        // Abort mid-capture at address 5, then start+abort together
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (o_wr[0] && o_addr[0] == 4'd5) found = 1'b1;
            else step();
        end
        chk_eq("abort_wait_addr5", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (30) step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) step();

        // Start during capture is ignored; start in the done cycle is accepted
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            start = (o_wr[0] && o_addr[0] == 4'd8);
            if (o_done[0]) begin
                start = 1'b1;
                found = 1'b1;
            end
            step();
        end
        start = 1'b0;
        chk_eq("restart_wait_done", 32'(found), 32'd1);
        repeat (40) step();

        // Reset while waiting for a trigger
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        // Random traffic around the threshold
        trig_level = 12'h400;
        for (int i = 0; i < 1500; i++) begin
            adc_data    = DATA_W'($urandom_range(12'h280, 12'h580));
            start       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            trig_rising = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) trig_level = DATA_W'($urandom_range(12'h300, 12'h500));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
